// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
// Pipelined N-bit barrel shifter/rotator with one register stage per
// shift-amount bit. The operating modes are rotate, logical shift,
// arithmetic shift and fill-ones shift, selected for either direction.
// The valid/ready handshake stalls the whole pipe when the output is held.
// Optional build macro: BS_ZERO_FLAG_EN adds a registered out_zero flag.
module barrel_shifter_pipe #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  logic          in_dir,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
`ifdef BS_ZERO_FLAG_EN
    ,
    output logic          out_zero
`endif
);

    // One stage step: move d by sh places and fill the vacated bits by mode.
    // sh is always a power of two below N, so (N - sh) never reaches N.
    function automatic logic [N-1:0] shift_stage(
        input logic [N-1:0] d,
        input int           sh,
        input logic         dir,
        input logic [1:0]   mode,
        input logic         sign
    );
        logic [N-1:0] ones_v;
        logic [N-1:0] base_v;
        logic [N-1:0] wrap_v;
        logic [N-1:0] fill_mask_v;
        ones_v = {N{1'b1}};
        if (dir == 1'b0) begin
            base_v      = d << sh;
            wrap_v      = d >> (N - sh);
            fill_mask_v = ~(ones_v << sh);
        end else begin
            base_v      = d >> sh;
            wrap_v      = d << (N - sh);
            fill_mask_v = ~(ones_v >> sh);
        end
        case (mode)
            2'b00:   shift_stage = base_v | wrap_v;
            2'b01:   shift_stage = base_v;
            2'b10:   shift_stage = (dir && sign) ? (base_v | fill_mask_v) : base_v;
            2'b11:   shift_stage = base_v | fill_mask_v;
            default: shift_stage = base_v;
        endcase
    endfunction

    // Per-stage pipeline registers
    logic [N-1:0]  data_r  [SW];
    logic [SW-1:0] amt_r   [SW];
    logic          dir_r   [SW];
    logic [1:0]    mode_r  [SW];
    logic          sign_r  [SW];
    logic          valid_r [SW];

    // Per-stage inputs (previous stage or the input port) and shifted result
    logic [N-1:0]  src_data_s  [SW];
    logic [SW-1:0] src_amt_s   [SW];
    logic          src_dir_s   [SW];
    logic [1:0]    src_mode_s  [SW];
    logic          src_sign_s  [SW];
    logic          src_valid_s [SW];
    logic [N-1:0]  nxt_data_s  [SW];
    logic          advance_s;

    // The whole pipe moves unless a valid result is waiting on a stalled sink
    always_comb begin
        advance_s = (!valid_r[SW-1]) || out_ready;
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_r[SW-1];
    assign out_data  = data_r[SW-1];

    // Route each stage's input: stage 0 from the ports, others from the stage before
    always_comb begin
        src_data_s[0]  = in_data;
        src_amt_s[0]   = in_amt;
        src_dir_s[0]   = in_dir;
        src_mode_s[0]  = in_mode;
        src_sign_s[0]  = in_data[N-1];
        src_valid_s[0] = in_valid;
        for (int k = 1; k < SW; k++) begin
            src_data_s[k]  = data_r[k-1];
            src_amt_s[k]   = amt_r[k-1];
            src_dir_s[k]   = dir_r[k-1];
            src_mode_s[k]  = mode_r[k-1];
            src_sign_s[k]  = sign_r[k-1];
            src_valid_s[k] = valid_r[k-1];
        end
    end

    // Stage k applies a 2^k step only when amount bit k is set
    always_comb begin
        for (int k = 0; k < SW; k++) begin
            if (src_amt_s[k][k]) begin
                nxt_data_s[k] = shift_stage(src_data_s[k], (1 << k), src_dir_s[k],
                                            src_mode_s[k], src_sign_s[k]);
            end else begin
                nxt_data_s[k] = src_data_s[k];
            end
        end
    end

    // Stage registers: clear on reset, advance together, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SW; k++) begin
                data_r[k]  <= {N{1'b0}};
                amt_r[k]   <= {SW{1'b0}};
                dir_r[k]   <= 1'b0;
                mode_r[k]  <= 2'b00;
                sign_r[k]  <= 1'b0;
                valid_r[k] <= 1'b0;
            end
        end else if (advance_s) begin
            for (int k = 0; k < SW; k++) begin
                data_r[k]  <= nxt_data_s[k];
                amt_r[k]   <= src_amt_s[k];
                dir_r[k]   <= src_dir_s[k];
                mode_r[k]  <= src_mode_s[k];
                sign_r[k]  <= src_sign_s[k];
                valid_r[k] <= src_valid_s[k];
            end
        end
    end

`ifdef BS_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag registered alongside the final data stage, qualified by valid
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_r <= 1'b0;
        end else if (advance_s) begin
            zero_r <= src_valid_s[SW-1] && (nxt_data_s[SW-1] == {N{1'b0}});
        end
    end

    assign out_zero = zero_r;
`else
    // No zero flag in this build.
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe
// Directed and random checks of barrel_shifter_pipe at N=8 and N=32 against
// a bit-by-bit reference model. Build with BS_ZERO_FLAG_EN to cover out_zero.
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    logic rst;

    logic        iv8, ir8, idir8, ov8, or8;
    logic [7:0]  id8, od8;
    logic [2:0]  ia8;
    logic [1:0]  imode8;
    logic        iv32, ir32, idir32, ov32, or32;
    logic [31:0] id32, od32;
    logic [4:0]  ia32;
    logic [1:0]  imode32;
`ifdef BS_ZERO_FLAG_EN
    logic        oz8, oz32;
`endif

    int compares = 0;
    int fails    = 0;
    int acc8     = 0;
    int acc32    = 0;
    logic [31:0] exp8_q[$];
    logic [31:0] exp32_q[$];

    always #5 clk = ~clk;

    barrel_shifter_pipe #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8),
        .in_dir(idir8), .in_mode(imode8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8)
`ifdef BS_ZERO_FLAG_EN
        , .out_zero(oz8)
`endif
    );

    barrel_shifter_pipe #(.N(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_amt(ia32),
        .in_dir(idir32), .in_mode(imode32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef BS_ZERO_FLAG_EN
        , .out_zero(oz32)
`endif
    );

    // Result bit i is taken from the source bit it lands on, or the fill value
    function automatic logic [31:0] ref_shift(input int n, input logic [31:0] d,
                                              input int a, input logic dir,
                                              input logic [1:0] mode);
        logic [31:0] r;
        logic fill;
        r = 32'd0;
        fill = (mode == 2'b11) || ((mode == 2'b10) && dir && d[n-1]);
        for (int i = 0; i < n; i++) begin
            if (mode == 2'b00)
                r[i] = dir ? d[(i + a) % n] : d[(i - a + n) % n];
            else if (!dir)
                r[i] = (i >= a) ? d[i - a] : fill;
            else
                r[i] = (i + a < n) ? d[i + a] : fill;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score outputs leaving, record beats entering, then step
    task automatic tick();
        logic [31:0] e;
        #1;
        if (ov8 && or8) begin
            if (exp8_q.size() == 0) check("extra8", {31'd0, ov8}, 32'd0);
            else begin
                e = exp8_q.pop_front();
                check("out8", {24'd0, od8}, e);
`ifdef BS_ZERO_FLAG_EN
                check("zero8", {31'd0, oz8}, {31'd0, (e == 32'd0)});
`endif
            end
        end
        if (ov32 && or32) begin
            if (exp32_q.size() == 0) check("extra32", {31'd0, ov32}, 32'd0);
            else begin
                e = exp32_q.pop_front();
                check("out32", od32, e);
`ifdef BS_ZERO_FLAG_EN
                check("zero32", {31'd0, oz32}, {31'd0, (e == 32'd0)});
`endif
            end
        end
        if (iv8 && ir8 && !rst) begin
            exp8_q.push_back(ref_shift(8, {24'd0, id8}, int'(ia8), idir8, imode8));
            acc8++;
        end
        if (iv32 && ir32 && !rst) begin
            exp32_q.push_back(ref_shift(32, id32, int'(ia32), idir32, imode32));
            acc32++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put8(input logic [7:0] d, input logic [2:0] a, input logic dir,
                        input logic [1:0] mode);
        iv8 = 1'b1; id8 = d; ia8 = a; idir8 = dir; imode8 = mode;
    endtask

    // Single beat with the sink ready: result must show up exactly L=3 edges later
    task automatic single8(input string tag, input logic [7:0] d, input logic [2:0] a,
                           input logic dir, input logic [1:0] mode, input logic [7:0] exp);
        or8 = 1'b1;
        put8(d, a, dir, mode);
        tick();
        iv8 = 1'b0;
        check({tag, "_lat1"}, {31'd0, ov8}, 32'd0);
        tick();
        check({tag, "_lat2"}, {31'd0, ov8}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, ov8}, 32'd1);
        check({tag, "_data"}, {24'd0, od8}, {24'd0, exp});
    endtask

    task automatic drain();
        or8 = 1'b1; or32 = 1'b1; iv8 = 1'b0; iv32 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp8_q.size() == 0 && exp32_q.size() == 0 && !ov8 && !ov32) break;
            tick();
        end
        check("drain8", exp8_q.size(), 32'd0);
        check("drain32", exp32_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] snap;
        int cyc;
        rst = 1'b1;
        iv8 = 1'b0; id8 = 8'd0; ia8 = 3'd0; idir8 = 1'b0; imode8 = 2'b00; or8 = 1'b0;
        iv32 = 1'b0; id32 = 32'd0; ia32 = 5'd0; idir32 = 1'b0; imode32 = 2'b00; or32 = 1'b1;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_ov8", {31'd0, ov8}, 32'd0);
        check("rst_od8", {24'd0, od8}, 32'd0);
        check("rst_ir8", {31'd0, ir8}, 32'd1);
        check("rst_ov32", {31'd0, ov32}, 32'd0);

        // Rotate left by 3, latency
        single8("rotl3", 8'b1001_0110, 3'd3, 1'b0, 2'b00, 8'b1011_0100);

        // Back-to-back beats on consecutive cycles
        or8 = 1'b1;
        put8(8'h80, 3'd7, 1'b1, 2'b10); tick();
        put8(8'h80, 3'd7, 1'b1, 2'b01); tick();
        put8(8'h0F, 3'd2, 1'b0, 2'b11); tick();
        iv8 = 1'b0;
        check("b2b_asr", {23'd0, ov8, od8}, {23'd0, 1'b1, 8'hFF});
        tick();
        check("b2b_lsr", {23'd0, ov8, od8}, {23'd0, 1'b1, 8'h01});
        tick();
        check("b2b_fill", {23'd0, ov8, od8}, {23'd0, 1'b1, 8'h3F});
        drain();

        // Stall: sink not ready, pipe fills and then holds
        or8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put8(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
            tick();
        end
        check("stall_ov", {31'd0, ov8}, 32'd1);
        snap = od8;
        for (int i = 0; i < 5; i++) begin
            put8(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
            tick();
            check("stall_ir", {31'd0, ir8}, 32'd0);
            check("stall_hold", {24'd0, od8}, {24'd0, snap});
        end
        drain();

        // amt = 0 is identity in every mode and direction
        for (int m = 0; m < 4; m++)
            for (int dr = 0; dr < 2; dr++)
                single8("amt0", 8'hA5, 3'd0, 1'(dr), 2'(m), 8'hA5);
        single8("rotr7", 8'h01, 3'd7, 1'b1, 2'b00, 8'h02);
        single8("lsr7", 8'hC3, 3'd7, 1'b1, 2'b01, 8'h01);

        // Zero results (also drive out_zero when built in)
        single8("lsl1_nz", 8'h01, 3'd1, 1'b0, 2'b01, 8'h02);
        single8("lsl1_z", 8'h80, 3'd1, 1'b0, 2'b01, 8'h00);
        drain();

        // Reset with three beats in flight discards them
        or8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put8(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
            tick();
        end
        iv8 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp8_q.delete();
        check("mrst_ov", {31'd0, ov8}, 32'd0);
        check("mrst_od", {24'd0, od8}, 32'd0);
        check("mrst_ir", {31'd0, ir8}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_stale", {31'd0, ov8}, 32'd0);
        end

        // Random sweep: 1000 beats at N=32, 300 at N=8, random backpressure
        acc8 = 0; acc32 = 0; cyc = 0;
        while ((acc32 < 1000 || acc8 < 300) && cyc < 6000) begin
            iv32 = (acc32 < 1000) && ($urandom_range(0, 3) != 0);
            id32 = 32'($urandom); ia32 = 5'($urandom); idir32 = 1'($urandom);
            imode32 = 2'($urandom);
            or32 = ($urandom_range(0, 3) != 0);
            iv8 = (acc8 < 300) && ($urandom_range(0, 1) != 0);
            id8 = 8'($urandom); ia8 = 3'($urandom); idir8 = 1'($urandom);
            imode8 = 2'($urandom);
            or8 = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        check("sweep_done32", acc32, 32'd1000);
        check("sweep_done8", acc8, 32'd300);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
